// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared port ids, state encoding and defaults for the SRAM arbiter
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    PORT_VID = 2'd0,
    PORT_GP1 = 2'd1,
    PORT_GP2 = 2'd2
  } port_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // One-hot completion vector for the port that owns an access
  function automatic logic [2:0] port_onehot(port_id_t p);
    case (p)
      PORT_VID: return 3'b001;
      PORT_GP1: return 3'b010;
      PORT_GP2: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational winner selection: video priority, starvation guard, round-robin
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  logic     req2,
  input  logic     starve_hit,
  input  logic     rr_ptr,
  output port_id_t winner,
  output logic     valid
);

  logic     gp_any;
  port_id_t gp_win;

  // Video wins unless it has hit its consecutive-grant limit while a general port waits
  always_comb begin
    gp_any = req1 | req2;
    if (rr_ptr == 1'b0) begin
      gp_win = req1 ? PORT_GP1 : PORT_GP2;
    end else begin
      gp_win = req2 ? PORT_GP2 : PORT_GP1;
    end
    valid  = req0 | gp_any;
    winner = PORT_VID;
    if (gp_any && (!req0 || starve_hit)) begin
      winner = gp_win;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-port SRAM access arbiter with req/done handshake and timeout
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk_100,
  input  logic              sys_reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  input  logic              req2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic              gnt2,
  output logic              rvalid2,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  port_id_t          own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic              err_q, err_d;

  port_id_t win_id;
  logic     win_valid;
  logic     starve_hit;
  logic     gp_pending;
  logic     grant;

  assign starve_hit = (starve_q == SW'(STARVE_MAX));
  assign gp_pending = req1 | req2;
  // Grants only from IDLE, and never while reset is held so outputs stay quiet
  assign grant      = (state_q == ST_IDLE) && win_valid && !sys_reset;

  sram_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .req2       (req2),
    .starve_hit (starve_hit),
    .rr_ptr     (rr_ptr_q),
    .winner     (win_id),
    .valid      (win_valid)
  );

  // Next-state, access latching, grant pulses and completion handling
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    rr_ptr_d = rr_ptr_q;
    rvalid_d = 3'b000;
    err_d    = err_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    gnt2     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          own_d   = win_id;
          tmo_d   = '0;
          state_d = ST_ISSUE;
          case (win_id)
            PORT_VID: begin
              gnt0    = 1'b1;
              we_d    = 1'b0;
              addr_d  = addr0;
              wdata_d = '0;
              // Count only video grants that actually made a general port wait
              if (gp_pending) begin
                starve_d = starve_hit ? starve_q : starve_q + 1'b1;
              end else begin
                starve_d = '0;
              end
            end
            PORT_GP1: begin
              gnt1     = 1'b1;
              we_d     = we1;
              addr_d   = addr1;
              wdata_d  = wdata1;
              starve_d = '0;
              rr_ptr_d = 1'b1;
            end
            default: begin
              gnt2     = 1'b1;
              we_d     = we2;
              addr_d   = addr2;
              wdata_d  = wdata2;
              starve_d = '0;
              rr_ptr_d = 1'b0;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_done) begin
          state_d  = ST_IDLE;
          rvalid_d = port_onehot(own_q);
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          rvalid_d = port_onehot(own_q);
          rdata_d  = '0;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and access registers; reset abandons any access in flight
  always_ff @(posedge clk_100) begin
    if (sys_reset) begin
      state_q  <= ST_IDLE;
      own_q    <= PORT_VID;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
      rr_ptr_q <= 1'b0;
      rvalid_q <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign mem_req   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rvalid2   = rvalid_q[2];
  assign err       = err_q;

endmodule
